// File: rtl/switch_input_port.sv
// ============================================================================
// Module   : switch_input_port
// Function : Memory-mapped DIP-switch input port with a debounced confirm key.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_input_port #(
    parameter int unsigned DEBOUNCE_CYCLES = 200000,
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FC70
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] switchInput,
    input  logic        enter,
    input  logic [31:0] address,
    input  logic        ioRead,
    output logic [15:0] dataIOInput,
    output logic        dataValid,
    output logic        overrun,
    output logic        pressPulse
);

    localparam int unsigned        c_CNT_W       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST    = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX     = '1;
    localparam logic [31:0]        c_ADDR_DATA   = BASE_ADDR;
    localparam logic [31:0]        c_ADDR_RAW    = BASE_ADDR + 32'd2;
    localparam logic [31:0]        c_ADDR_STATUS = BASE_ADDR + 32'd4;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    logic               enter_meta_q;
    logic               enter_sync_q;
    logic [15:0]        sw_meta_q;
    logic [15:0]        sw_sync_q;
    state_t             state_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic               pressPulse_q;
    logic [15:0]        dataReg_q;
    logic [15:0]        dataReg_d;
    logic               dataValid_q;
    logic               dataValid_d;
    logic               overrun_q;
    logic               overrun_d;

    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               w_rd_data;
    logic               w_rd_raw;
    logic               w_rd_status;

    // Two-flop synchronizers; nothing downstream sees the raw pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enter_meta_q <= 1'b0;
            enter_sync_q <= 1'b0;
            sw_meta_q    <= 16'h0000;
            sw_sync_q    <= 16'h0000;
        end else begin
            enter_meta_q <= enter;
            enter_sync_q <= enter_meta_q;
            sw_meta_q    <= switchInput;
            sw_sync_q    <= sw_meta_q;
        end
    end

    assign w_cnt_inc = (cnt_q == c_CNT_MAX) ? cnt_q : cnt_q + c_CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LOW;
            cnt_q        <= '0;
            pressPulse_q <= 1'b0;
        end else begin
            pressPulse_q <= 1'b0;
            case (state_q)
                LOW: begin
                    if (enter_sync_q) begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!enter_sync_q) begin
                        state_q <= LOW;
                        cnt_q   <= '0;
                    end else if (w_cnt_inc >= c_CNT_LAST) begin
                        state_q      <= HIGH;
                        cnt_q        <= '0;
                        pressPulse_q <= 1'b1;
                    end else begin
                        cnt_q <= w_cnt_inc;
                    end
                end
                HIGH: begin
                    if (!enter_sync_q) begin
                        state_q <= WAIT_LOW;
                        cnt_q   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (enter_sync_q) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                    end else if (w_cnt_inc >= c_CNT_LAST) begin
                        state_q <= LOW;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= w_cnt_inc;
                    end
                end
                default: begin
                    state_q <= LOW;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign w_rd_data   = ioRead && (address == c_ADDR_DATA);
    assign w_rd_raw    = ioRead && (address == c_ADDR_RAW);
    assign w_rd_status = ioRead && (address == c_ADDR_STATUS);

    always_comb begin
        dataIOInput = 16'h0000;
        if (w_rd_data) begin
            dataIOInput = dataReg_q;
        end else if (w_rd_raw) begin
            dataIOInput = sw_sync_q;
        end else if (w_rd_status) begin
            dataIOInput = {14'b0, overrun_q, dataValid_q};
        end
    end

    // A press wins over a same-cycle clear: the read already returned the old word.
    always_comb begin
        dataReg_d   = dataReg_q;
        dataValid_d = dataValid_q;
        overrun_d   = overrun_q;
        if (pressPulse_q) begin
            dataReg_d   = sw_sync_q;
            dataValid_d = 1'b1;
            if (dataValid_q && !w_rd_data) begin
                overrun_d = 1'b1;
            end else if (w_rd_status) begin
                overrun_d = 1'b0;
            end
        end else begin
            if (w_rd_data) begin
                dataValid_d = 1'b0;
            end
            if (w_rd_status) begin
                overrun_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataReg_q   <= 16'h0000;
            dataValid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            dataReg_q   <= dataReg_d;
            dataValid_q <= dataValid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign dataValid  = dataValid_q;
    assign overrun    = overrun_q;
    assign pressPulse = pressPulse_q;

endmodule

`default_nettype wire

// File: tb/tb_switch_input_port.sv
// ============================================================================
// Module   : tb_switch_input_port
// Function : Self-checking bench for switch_input_port (DEBOUNCE_CYCLES = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_input_port;

    localparam int          c_DEB  = 4;
    localparam logic [31:0] c_BASE = 32'hFFFF_FC70;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] switchInput;
    logic        enter;
    logic [31:0] address;
    logic        ioRead;
    logic [15:0] dataIOInput;
    logic        dataValid;
    logic        overrun;
    logic        pressPulse;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: debounced level flips after c_DEB consecutive synced samples that disagree with it.
    logic        m_s1, m_s2, m_level, m_pulse, m_valid, m_ovr;
    logic [15:0] m_sw1, m_sw2, m_data;
    int          m_run;

    switch_input_port #(
        .DEBOUNCE_CYCLES(c_DEB),
        .BASE_ADDR      (c_BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .switchInput(switchInput),
        .enter      (enter),
        .address    (address),
        .ioRead     (ioRead),
        .dataIOInput(dataIOInput),
        .dataValid  (dataValid),
        .overrun    (overrun),
        .pressPulse (pressPulse)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_level = 0; m_pulse = 0; m_valid = 0; m_ovr = 0;
        m_sw1 = 0; m_sw2 = 0; m_data = 0; m_run = 0;
    endtask

    task automatic model_step();
        logic [31:0] off;
        logic        rd_d, rd_s, np;
        if (rst) begin
            model_reset();
            return;
        end
        off  = address - c_BASE;
        rd_d = ioRead && (off == 32'd0);
        rd_s = ioRead && (off == 32'd4);
        np   = 1'b0;
        if (m_s2 != m_level) begin
            m_run++;
            if (m_run == c_DEB) begin
                m_level = !m_level;
                m_run   = 0;
                np      = m_level;
            end
        end else begin
            m_run = 0;
        end
        if (m_pulse) begin
            m_data = m_sw2;
            if (m_valid && !rd_d) m_ovr = 1'b1;
            else if (rd_s)        m_ovr = 1'b0;
            m_valid = 1'b1;
        end else begin
            if (rd_d) m_valid = 1'b0;
            if (rd_s) m_ovr   = 1'b0;
        end
        m_pulse = np;
        m_s2 = m_s1;   m_s1 = enter;
        m_sw2 = m_sw1; m_sw1 = switchInput;
    endtask

    function automatic logic [15:0] exp_rd();
        logic [31:0] off;
        off = address - c_BASE;
        if (!ioRead)           return 16'h0000;
        if (off == 32'd0)      return m_data;
        else if (off == 32'd2) return m_sw2;
        else if (off == 32'd4) return {14'b0, m_ovr, m_valid};
        return 16'h0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic press_word(input logic [15:0] w);
        switchInput = w;
        enter = 1'b1;
        repeat (8) tick();
        enter = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; model_reset();
        ioRead = 1'b1; address = c_BASE;
        tick(); tick();
        #1;
        n_checks++; if (pressPulse !== 1'b0) begin n_errors++; $display("FAIL reset_pulse: got %b want 0", pressPulse); end
        n_checks++; if (dataValid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", dataValid); end
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_checks++; if (dataIOInput !== 16'h0000) begin n_errors++; $display("FAIL reset_data: got %h want 0000", dataIOInput); end
        address = c_BASE + 32'd4; #1;
        n_checks++; if (dataIOInput !== 16'h0000) begin n_errors++; $display("FAIL reset_status: got %h want 0000", dataIOInput); end
        ioRead = 1'b0; address = 32'h0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_clean_press();
        int pulses = 0;
        int pcyc = -1;
        switchInput = 16'hA5A5; enter = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++; if (pressPulse !== m_pulse) begin n_errors++; $display("FAIL clean_pulse c%0d: got %b want %b", i, pressPulse, m_pulse); end
            if (pressPulse === 1'b1) begin pulses++; if (pcyc < 0) pcyc = i; end
        end
        n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL clean_pulse_count: got %0d want 1", pulses); end
        n_checks++; if (pcyc != 6) begin n_errors++; $display("FAIL clean_latency: got %0d want 6", pcyc); end
        enter = 1'b0;
        ioRead = 1'b1; address = c_BASE + 32'd4; #1;
        n_checks++; if (dataIOInput !== 16'h0001) begin n_errors++; $display("FAIL clean_status1: got %h want 0001", dataIOInput); end
        tick();
        address = c_BASE; #1;
        n_checks++; if (dataIOInput !== 16'hA5A5) begin n_errors++; $display("FAIL clean_data: got %h want a5a5", dataIOInput); end
        tick();
        address = c_BASE + 32'd4; #1;
        n_checks++; if (dataIOInput !== 16'h0000) begin n_errors++; $display("FAIL clean_status2: got %h want 0000", dataIOInput); end
        tick();
        ioRead = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_bounce();
        switchInput = 16'h5555;
        for (int r = 0; r < 5; r++) begin
            enter = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (k == 3) enter = 1'b0;
                tick();
                n_checks++; if (pressPulse !== 1'b0) begin n_errors++; $display("FAIL bounce_pulse r%0d k%0d: got %b want 0", r, k, pressPulse); end
            end
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++; if (pressPulse !== 1'b0) begin n_errors++; $display("FAIL bounce_tail k%0d: got %b want 0", k, pressPulse); end
        end
        n_checks++; if (dataValid !== 1'b0) begin n_errors++; $display("FAIL bounce_valid: got %b want 0", dataValid); end
    endtask

    task automatic test_overrun();
        press_word(16'h0001);
        press_word(16'h0002);
        ioRead = 1'b1; address = c_BASE + 32'd4; #1;
        n_checks++; if (dataIOInput !== 16'h0003) begin n_errors++; $display("FAIL ovr_status1: got %h want 0003", dataIOInput); end
        tick(); #1;
        n_checks++; if (dataIOInput !== 16'h0001) begin n_errors++; $display("FAIL ovr_status2: got %h want 0001", dataIOInput); end
        tick();
        address = c_BASE; #1;
        n_checks++; if (dataIOInput !== 16'h0002) begin n_errors++; $display("FAIL ovr_data: got %h want 0002", dataIOInput); end
        tick();
        ioRead = 1'b0;
        n_checks++; if (dataValid !== 1'b0) begin n_errors++; $display("FAIL ovr_valid_clr: got %b want 0", dataValid); end
    endtask

    task automatic test_read_collision();
        logic found = 1'b0;
        press_word(16'h1111);
        switchInput = 16'h2222; enter = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_pulse) begin
                n_checks++; if (pressPulse !== 1'b1) begin n_errors++; $display("FAIL coll_pulse: got %b want 1", pressPulse); end
                ioRead = 1'b1; address = c_BASE; #1;
                n_checks++; if (dataIOInput !== 16'h1111) begin n_errors++; $display("FAIL coll_old: got %h want 1111", dataIOInput); end
                tick();
                ioRead = 1'b0;
                n_checks++; if (dataValid !== 1'b1) begin n_errors++; $display("FAIL coll_valid: got %b want 1", dataValid); end
                n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL coll_overrun: got %b want 0", overrun); end
                found = 1'b1;
                break;
            end
        end
        if (!found) begin n_checks++; n_errors++; $display("FAIL coll_timeout: got no pulse want pulse within 20 cycles"); end
        ioRead = 1'b1; address = c_BASE; #1;
        n_checks++; if (dataIOInput !== 16'h2222) begin n_errors++; $display("FAIL coll_new: got %h want 2222", dataIOInput); end
        tick();
        ioRead = 1'b0; enter = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_async_reset();
        int pcyc = -1;
        press_word(16'h5A5A);
        press_word(16'h5A5A);
        n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL ares_pre_ovr: got %b want 1", overrun); end
        switchInput = 16'h3C3C; enter = 1'b1;
        repeat (5) tick();
        #2; rst = 1'b1; model_reset();
        ioRead = 1'b1; address = c_BASE; #1;
        n_checks++; if ({pressPulse, dataValid, overrun} !== 3'b000) begin n_errors++; $display("FAIL ares_flags: got %b want 000", {pressPulse, dataValid, overrun}); end
        n_checks++; if (dataIOInput !== 16'h0000) begin n_errors++; $display("FAIL ares_data: got %h want 0000", dataIOInput); end
        ioRead = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++; if (pressPulse !== m_pulse) begin n_errors++; $display("FAIL ares_pulse c%0d: got %b want %b", i, pressPulse, m_pulse); end
            if (pressPulse === 1'b1 && pcyc < 0) pcyc = i;
        end
        n_checks++; if (pcyc != 6) begin n_errors++; $display("FAIL ares_latency: got %0d want 6", pcyc); end
        enter = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_unmapped();
        logic [31:0] offs [4] = '{32'd8, 32'd6, 32'd1, 32'hFFFF_FFFC};
        ioRead = 1'b1;
        for (int k = 0; k < 4; k++) begin
            address = c_BASE + offs[k]; #1;
            n_checks++; if (dataIOInput !== 16'h0000) begin n_errors++; $display("FAIL unmap_rd off=%h: got %h want 0000", offs[k], dataIOInput); end
            tick();
        end
        ioRead = 1'b0;
        address = c_BASE; #1;
        n_checks++; if (dataIOInput !== 16'h0000) begin n_errors++; $display("FAIL noread_data: got %h want 0000", dataIOInput); end
        tick();
        address = c_BASE + 32'd4; #1;
        n_checks++; if (dataIOInput !== 16'h0000) begin n_errors++; $display("FAIL noread_status: got %h want 0000", dataIOInput); end
        tick();
        n_checks++; if (dataValid !== 1'b1) begin n_errors++; $display("FAIL unmap_valid: got %b want 1", dataValid); end
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL unmap_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int n = 0; n < 400; n++) begin
            if (hold == 0) begin
                enter = 1'($urandom_range(0, 1));
                hold  = $urandom_range(1, 9);
            end
            hold--;
            switchInput = 16'($urandom);
            ioRead = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0: address = c_BASE;
                1: address = c_BASE + 32'd2;
                2: address = c_BASE + 32'd4;
                3: address = c_BASE + 32'd8;
                default: address = $urandom;
            endcase
            #1;
            n_checks++; if (dataIOInput !== exp_rd()) begin n_errors++; $display("FAIL rand_rd n%0d addr=%h: got %h want %h", n, address, dataIOInput, exp_rd()); end
            tick();
            n_checks++; if ({pressPulse, dataValid, overrun} !== {m_pulse, m_valid, m_ovr}) begin
                n_errors++; $display("FAIL rand_flags n%0d: got %b want %b", n, {pressPulse, dataValid, overrun}, {m_pulse, m_valid, m_ovr});
            end
        end
        ioRead = 1'b0; enter = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enter = 1'b0; switchInput = 16'h0000; address = 32'h0; ioRead = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_overrun();
        test_read_collision();
        test_async_reset();
        test_unmapped();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
